// File: rtl/wb_modport_pkg.sv
// Shared types for the wb_modport Wishbone classic device endpoint.
// FSM states, response codes and the occupancy-width helper.
package wb_modport_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      R_NONE,
      R_ACK,
      R_RTY,
      R_ERR
   } resp_t;

   // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wb_modport_fifo.sv
// Synchronous FIFO behind the wb_modport endpoint; asynchronous active-low reset
// clears pointers and level, storage is left untouched.
module wb_modport_fifo
   import wb_modport_pkg::*;
#(
   parameter int DAT_WIDTH = 8,
   parameter int DEPTH     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DAT_WIDTH-1:0]          din,
   output logic [DAT_WIDTH-1:0]          head,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   logic [DAT_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_modport.sv
// Wishbone B4 classic device endpoint: writes push dat_i, reads pop the FIFO head.
// Define WB_MODPORT_ASYNC_ACK_EN for same-cycle combinational responses.
module wb_modport
   import wb_modport_pkg::*;
#(
   parameter int DAT_WIDTH   = 8,
   parameter int DEPTH       = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cyc_i,
   input  logic                          stb_i,
   input  logic                          we_i,
   input  logic [DAT_WIDTH-1:0]          dat_i,
   output logic [DAT_WIDTH-1:0]          dat_o,
   output logic                          ack_o,
   output logic                          rty_o,
   output logic                          err_o,
   output logic [level_width(DEPTH)-1:0] level_o,
   output logic                          full_o,
   output logic                          empty_o
);

   resp_t                resp;
   logic                 req;
   logic                 push;
   logic                 pop;
   logic                 rd_sel;
   logic [DAT_WIDTH-1:0] wr_data;
   logic [DAT_WIDTH-1:0] head;

   assign req = cyc_i && stb_i;

   wb_modport_fifo #(
      .DAT_WIDTH (DAT_WIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .din   (wr_data),
      .head  (head),
      .level (level_o),
      .full  (full_o),
      .empty (empty_o)
   );

`ifdef WB_MODPORT_ASYNC_ACK_EN
   always_comb begin
      resp = R_NONE;
      if (req) resp = (we_i ? full_o : empty_o) ? R_RTY : R_ACK;
   end

   assign wr_data = dat_i;
   assign rd_sel  = !we_i;
   assign push    = (resp == R_ACK) && we_i;
   assign pop     = (resp == R_ACK) && !we_i;
`else
   localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

   state_t               state;
   state_t               state_nx;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nx;
   logic                 we_q;
   logic                 we_nx;
   logic                 err_q;
   logic                 err_nx;
   logic [DAT_WIDTH-1:0] dat_q;
   logic [DAT_WIDTH-1:0] dat_nx;
   logic                 changed;

   // The controller must hold the request unchanged until it is answered.
   assign changed = !stb_i || (we_i != we_q) || (dat_i != dat_q);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
         cnt   <= '0;
         we_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         we_q  <= we_nx;
         err_q <= err_nx;
      end
   end

   always_ff @(posedge clk_i) begin
      dat_q <= dat_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      we_nx    = we_q;
      err_nx   = err_q;
      dat_nx   = dat_q;
      resp     = R_NONE;
      case (state)
         S_IDLE: begin
            if (req) begin
               we_nx    = we_i;
               dat_nx   = dat_i;
               err_nx   = 1'b0;
               cnt_nx   = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
               state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (!cyc_i) begin
               state_nx = S_IDLE;
            end else if (changed) begin
               err_nx   = 1'b1;
               state_nx = S_RESP;
            end else if (cnt == '0) begin
               state_nx = S_RESP;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_RESP: begin
            state_nx = S_IDLE;
            if (err_q)                          resp = R_ERR;
            else if (we_q ? full_o : empty_o)   resp = R_RTY;
            else                                resp = R_ACK;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign wr_data = dat_q;
   assign rd_sel  = !we_q;
   assign push    = (resp == R_ACK) && we_q;
   assign pop     = (resp == R_ACK) && !we_q;
`endif

   assign ack_o = (resp == R_ACK);
   assign rty_o = (resp == R_RTY);
   assign err_o = (resp == R_ERR);
   assign dat_o = (ack_o && rd_sel) ? head : '0;

endmodule

// File: tb/tb_wb_modport.sv
// Self-checking bench for wb_modport: queue-based reference model checked every
// cycle, plus directed transactions with literal expectations.
module tb_wb_modport;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int WS    = 2;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int K_ACK = 1;
   localparam int K_RTY = 2;
   localparam int K_ERR = 3;
`ifdef WB_MODPORT_ASYNC_ACK_EN
   localparam int EXP_LAT = 0;
   localparam int EXP_GAP = 1;
`else
   localparam int EXP_LAT = 1 + WS;
   localparam int EXP_GAP = 2 + WS;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          cyc_i = 1'b0;
   logic          stb_i = 1'b0;
   logic          we_i  = 1'b0;
   logic [DW-1:0] dat_i = '0;
   logic [DW-1:0] dat_o;
   logic          ack_o;
   logic          rty_o;
   logic          err_o;
   logic [LW-1:0] level_o;
   logic          full_o;
   logic          empty_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   wb_modport #(
      .DAT_WIDTH   (DW),
      .DEPTH       (DEPTH),
      .WAIT_STATES (WS)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cyc_i   (cyc_i),
      .stb_i   (stb_i),
      .we_i    (we_i),
      .dat_i   (dat_i),
      .dat_o   (dat_o),
      .ack_o   (ack_o),
      .rty_o   (rty_o),
      .err_o   (err_o),
      .level_o (level_o),
      .full_o  (full_o),
      .empty_o (empty_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, pending request described by
   // the cycle number in which its answer is due.
   logic [DW-1:0] q[$];
   bit            busy    = 1'b0;
   bit            lat_we  = 1'b0;
   bit            lat_err = 1'b0;
   logic [DW-1:0] lat_dat = '0;
   int            resp_at = 0;
   int            cyc_cnt = 0;

   always @(negedge clk_i) begin
      bit            req, e_ack, e_rty, e_err, pw;
      logic [DW-1:0] e_dat, pd;
      cyc_cnt++;
      e_ack = 0; e_rty = 0; e_err = 0; pw = 0; e_dat = '0; pd = '0;
      if (!rst_i) begin
         q.delete();
         busy = 0;
      end else begin
         req = cyc_i && stb_i;
`ifdef WB_MODPORT_ASYNC_ACK_EN
         if (req) begin
            if (we_i ? (q.size() < DEPTH) : (q.size() > 0)) e_ack = 1;
            else e_rty = 1;
         end
         pw = we_i;
         pd = dat_i;
`else
         if (busy && cyc_cnt == resp_at) begin
            busy = 0;
            if (lat_err) e_err = 1;
            else if (lat_we ? (q.size() == DEPTH) : (q.size() == 0)) e_rty = 1;
            else e_ack = 1;
         end else if (busy) begin
            if (!cyc_i) busy = 0;
            else if (!stb_i || we_i != lat_we || dat_i != lat_dat) begin
               lat_err = 1;
               resp_at = cyc_cnt + 1;
            end
         end else if (req) begin
            busy    = 1;
            lat_we  = we_i;
            lat_dat = dat_i;
            lat_err = 0;
            resp_at = cyc_cnt + 1 + WS;
         end
         pw = lat_we;
         pd = lat_dat;
`endif
         if (e_ack && !pw) e_dat = q[0];
         chk("m_level", 32'(level_o), q.size());
         chk("m_full", full_o, q.size() == DEPTH);
         chk("m_empty", empty_o, q.size() == 0);
         chk("m_ack", ack_o, e_ack);
         chk("m_rty", rty_o, e_rty);
         chk("m_err", err_o, e_err);
         chk("m_dat", dat_o, e_dat);
         if (e_ack) begin
            if (pw) q.push_back(pd);
            else void'(q.pop_front());
         end
      end
   end

   task automatic drive(input bit c, input bit s, input bit w, input logic [DW-1:0] d);
      cyc_i = c; stb_i = s; we_i = w; dat_i = d;
   endtask

   task automatic xfer(input bit w, input logic [DW-1:0] d, output int kind,
                       output logic [DW-1:0] rd, output int lat);
      bit got;
      got = 0; kind = 0; rd = '0; lat = -1;
      @(posedge clk_i); #1;
      drive(1, 1, w, d);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk_i);
         if (ack_o || rty_o || err_o) begin
            got  = 1;
            lat  = i;
            kind = ack_o ? K_ACK : (rty_o ? K_RTY : K_ERR);
            rd   = dat_o;
         end
      end
      chk("xfer_response_seen", got, 1);
      @(posedge clk_i); #1;
      drive(0, 0, 0, '0);
   endtask

   initial begin
      int            k, lat, npulse, wbias;
      logic [DW-1:0] rd;
      int            t_ack[$];

      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_ack", ack_o, 0);
      chk("rst_level", 32'(level_o), 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_full", full_o, 0);
      @(posedge clk_i); #3;
      rst_i = 1'b1;

      xfer(1, 8'hA5, k, rd, lat);
      chk("wr_a5_kind", k, K_ACK);
      chk("wr_a5_latency", lat, EXP_LAT);
      chk("wr_a5_level", 32'(level_o), 1);
      xfer(0, 8'h00, k, rd, lat);
      chk("rd_a5_kind", k, K_ACK);
      chk("rd_a5_data", rd, 8'hA5);
      chk("rd_a5_level", 32'(level_o), 0);

      for (int i = 1; i <= 4; i++) begin
         xfer(1, DW'(i), k, rd, lat);
         chk("fill_kind", k, K_ACK);
      end
      xfer(1, 8'h05, k, rd, lat);
      chk("wr_full_kind", k, K_RTY);
      chk("wr_full_level", 32'(level_o), 4);
      chk("wr_full_flag", full_o, 1);
      for (int i = 1; i <= 4; i++) begin
         xfer(0, 8'h00, k, rd, lat);
         chk("drain_kind", k, K_ACK);
         chk("drain_data", rd, 32'(i));
      end
      xfer(0, 8'h00, k, rd, lat);
      chk("rd_empty_kind", k, K_RTY);
      chk("rd_empty_flag", empty_o, 1);

`ifndef WB_MODPORT_ASYNC_ACK_EN
      xfer(1, 8'h33, k, rd, lat);
      chk("pre_err_kind", k, K_ACK);
      @(posedge clk_i); #1;
      drive(1, 1, 1, 8'h44);
      @(posedge clk_i); #1;
      dat_i = 8'h45;
      k = 0;
      for (int i = 0; i < 10 && k == 0; i++) begin
         @(negedge clk_i);
         if (ack_o) k = K_ACK;
         else if (rty_o) k = K_RTY;
         else if (err_o) k = K_ERR;
      end
      chk("chg_kind", k, K_ERR);
      @(posedge clk_i); #1;
      drive(0, 0, 0, '0);
      @(negedge clk_i);
      chk("chg_level", 32'(level_o), 1);

      drive(1, 1, 1, 8'h55);
      @(posedge clk_i); #1;
      drive(0, 0, 1, 8'h55);
      npulse = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         if (ack_o || rty_o || err_o) npulse++;
      end
      chk("abort_pulses", npulse, 0);
      chk("abort_level", 32'(level_o), 1);
      xfer(0, 8'h00, k, rd, lat);
      chk("post_abort_data", rd, 8'h33);

      xfer(1, 8'h77, k, rd, lat);
      drive(1, 1, 1, 8'h88);
      @(posedge clk_i); #1;
      @(negedge clk_i); #2;
      rst_i = 1'b0;
      #1;
      chk("mid_rst_ack", ack_o, 0);
      chk("mid_rst_rty", rty_o, 0);
      chk("mid_rst_err", err_o, 0);
      chk("mid_rst_dat", dat_o, 0);
      chk("mid_rst_level", 32'(level_o), 0);
      chk("mid_rst_empty", empty_o, 1);
      chk("mid_rst_full", full_o, 0);
      drive(0, 0, 0, '0);
      @(negedge clk_i);
      @(posedge clk_i); #3;
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      chk("post_rst_level", 32'(level_o), 0);
`endif

      @(posedge clk_i); #1;
      drive(1, 1, 1, 8'h5A);
      for (int i = 0; i < 40 && t_ack.size() < 3; i++) begin
         @(negedge clk_i);
         if (ack_o) t_ack.push_back(i);
      end
      @(posedge clk_i); #1;
      drive(0, 0, 0, '0);
      chk("held_ack_count", t_ack.size(), 3);
      if (t_ack.size() == 3) begin
         chk("held_gap1", t_ack[1] - t_ack[0], EXP_GAP);
         chk("held_gap2", t_ack[2] - t_ack[1], EXP_GAP);
      end
      chk("held_level", 32'(level_o), 3);
      for (int i = 0; i < 3; i++) begin
         xfer(0, 8'h00, k, rd, lat);
         chk("held_data", rd, 8'h5A);
      end

      wbias = 70;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk_i); #1;
         if (c % 150 == 0) wbias = 100 - wbias;
         if ($urandom_range(3) == 0)
            drive($urandom_range(9) != 0, $urandom_range(4) != 0,
                  $urandom_range(99) < wbias, DW'($urandom));
         if (c == 700) begin #2; rst_i = 1'b0; end
         if (c == 702) begin #2; rst_i = 1'b1; end
      end
      @(posedge clk_i); #1;
      drive(0, 0, 0, '0);
      repeat (WS + 3) @(negedge clk_i);
      for (int i = 0; i < DEPTH + 2 && !empty_o; i++) xfer(0, 8'h00, k, rd, lat);
      @(negedge clk_i);
      chk("final_empty", empty_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
